// File: rtl/video_pkg.sv
// Shared definitions for the video frame monitor: CRC constants, the
// one-cycle CRC-16 update, the FSM state type and the frame report record.
package video_pkg;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  // Widest pixel word the CRC helper accepts (3 channels of up to 16 bits).
  localparam int          CRC_MAX_BITS = 48;
  // Width of the geometry fields carried in the report record.
  localparam int          COORD_MAX_W  = 16;

  typedef enum logic {
    MON_IDLE    = 1'b0,
    MON_MEASURE = 1'b1
  } mon_state_e;

  typedef struct packed {
    logic [COORD_MAX_W-1:0] width;
    logic [COORD_MAX_W-1:0] height;
    logic [15:0]            crc;
    logic                   geom_err;
    logic                   overrun;
  } frame_report_t;

  // Fold the low nbits of data into crc, MSB first, polynomial 0x1021,
  // no reflection and no final XOR. nbits is 3*COLSPC at every call site.
  function automatic logic [15:0] crc16_step(input logic [15:0]             crc,
                                             input logic [CRC_MAX_BITS-1:0] data,
                                             input int                      nbits);
    logic [15:0] c;
    logic        fb;
    c  = crc;
    fb = 1'b0;
    for (int i = CRC_MAX_BITS - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0};
        if (fb) begin
          c = c ^ CRC16_POLY;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/video_frame_monitor_if.sv
// Pixel stream in and frame report out of the video frame monitor.
// slave = the monitor, master = the video source plus the report consumer.
interface video_frame_monitor_if #(
  parameter int COLSPC   = 10,
  parameter int COORDSPC = 16
);

  logic                video_enable;
  logic                frame_start;
  logic                line_start;
  logic [COLSPC-1:0]   red;
  logic [COLSPC-1:0]   green;
  logic [COLSPC-1:0]   blue;

  logic                res_valid;
  logic                res_ready;
  logic [COORDSPC-1:0] res_width;
  logic [COORDSPC-1:0] res_height;
  logic [15:0]         res_crc;
  logic                res_geom_err;
  logic                res_overrun;

  modport master (
    output video_enable, frame_start, line_start, red, green, blue, res_ready,
    input  res_valid, res_width, res_height, res_crc, res_geom_err, res_overrun
  );

  modport slave (
    input  video_enable, frame_start, line_start, red, green, blue, res_ready,
    output res_valid, res_width, res_height, res_crc, res_geom_err, res_overrun
  );

endinterface

// File: rtl/video_crc16_acc.sv
// Running CRC-16 over a pixel stream. clr reseeds to 0xFFFF; when clr and en
// coincide the current pixel is folded into the fresh seed.
module video_crc16_acc
  import video_pkg::*;
#(
  parameter int PIX_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] data,
  output logic [15:0]      crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] seed;

  // Next CRC: pick the seed, then optionally fold in this cycle's pixel.
  always_comb begin
    seed  = clr ? CRC16_INIT : crc_q;
    crc_d = en ? crc16_step(seed, CRC_MAX_BITS'(data), PIX_W) : seed;
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/video_frame_monitor.sv
// Sink-side frame checker: measures active width/height, CRCs the active
// pixels and reports each completed frame on a valid/ready port.
module video_frame_monitor
  import video_pkg::*;
#(
  parameter int COORDSPC = 16,
  parameter int COLSPC   = 10,
  parameter int H_RES    = 1280,
  parameter int V_RES    = 720
) (
  input  logic                  video_clk_pix,
  input  logic                  video_rst_n,
  video_frame_monitor_if.slave  vif
);

  localparam int                  PIX_W   = 3 * COLSPC;
  localparam logic [COORDSPC-1:0] CNT_MAX = '1;
  localparam logic [COORDSPC-1:0] H_EXP   = COORDSPC'(H_RES);
  localparam logic [COORDSPC-1:0] V_EXP   = COORDSPC'(V_RES);

  function automatic logic [COORDSPC-1:0] sat_inc(input logic [COORDSPC-1:0] v);
    return (v == CNT_MAX) ? v : v + COORDSPC'(1);
  endfunction

  mon_state_e          state_q, state_d;
  logic                fsm_measuring;
  logic                fsm_frame_begin;
  logic                fsm_frame_close;
  logic                fsm_pix_en;

  logic                en_q, en_d;
  logic [COORDSPC-1:0] pix_cnt_q, pix_cnt_d;
  logic [COORDSPC-1:0] line_cnt_q, line_cnt_d;
  logic [COORDSPC-1:0] width_q, width_d;
  logic                geom_q, geom_d;

  logic                line_close;
  logic [COORDSPC-1:0] line_cnt_cl;
  logic [COORDSPC-1:0] width_cl;
  logic                geom_cl;
  logic [COORDSPC-1:0] pix_base;

  logic                valid_q, valid_d;
  logic                drop_q, drop_d;
  frame_report_t       rep_q, rep_d;
  frame_report_t       rep_new;
  logic                xfer;
  logic                load;
  logic                drop;

  logic [15:0]         crc_cur;

  // FSM state register.
  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      state_q <= MON_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: wait for the first frame_start, then measure forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MON_IDLE:    if (vif.frame_start) state_d = MON_MEASURE;
      MON_MEASURE: state_d = MON_MEASURE;
      default:     state_d = MON_IDLE;
    endcase
  end

  // FSM outputs: frame_start always opens a frame, but only closes one (and
  // produces a report) when a frame was actually being measured.
  always_comb begin
    fsm_measuring   = (state_q == MON_MEASURE);
    fsm_frame_begin = vif.frame_start;
    fsm_frame_close = fsm_measuring && vif.frame_start;
    fsm_pix_en      = vif.video_enable && (fsm_measuring || vif.frame_start);
  end

  // Geometry accumulators. The "_cl" values are the current frame's totals
  // after any line that closes this cycle; they feed both the running
  // counters and the report formed at frame close.
  always_comb begin
    line_close  = fsm_measuring && en_q && (!vif.video_enable || vif.frame_start);
    line_cnt_cl = line_close ? sat_inc(line_cnt_q) : line_cnt_q;
    width_cl    = (line_close && (line_cnt_q == '0)) ? pix_cnt_q : width_q;
    geom_cl     = geom_q | (line_close && (pix_cnt_q != H_EXP));
    // line_start restarts the pixel count without closing the line.
    pix_base    = (line_close || vif.line_start) ? '0 : pix_cnt_q;

    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    width_d    = width_q;
    geom_d     = geom_q;
    if (fsm_frame_begin) begin
      // A pixel on the frame_start cycle already belongs to the new frame.
      pix_cnt_d  = vif.video_enable ? COORDSPC'(1) : '0;
      line_cnt_d = '0;
      width_d    = '0;
      geom_d     = 1'b0;
    end else if (fsm_measuring) begin
      pix_cnt_d  = vif.video_enable ? sat_inc(pix_base) : pix_base;
      line_cnt_d = line_cnt_cl;
      width_d    = width_cl;
      geom_d     = geom_cl;
    end

    en_d = (fsm_measuring || fsm_frame_begin) ? vif.video_enable : 1'b0;
  end

  // Report slot with single-entry valid/ready. A close that finds the slot
  // occupied and not draining is dropped; the drop flag is handed to the next
  // report that loads, which then carries overrun=1.
  always_comb begin
    rep_new.width    = COORD_MAX_W'(width_cl);
    rep_new.height   = COORD_MAX_W'(line_cnt_cl);
    rep_new.crc      = crc_cur;
    rep_new.geom_err = geom_cl | (line_cnt_cl != V_EXP);
    rep_new.overrun  = drop_q;

    xfer    = valid_q && vif.res_ready;
    load    = fsm_frame_close && (!valid_q || xfer);
    drop    = fsm_frame_close && valid_q && !vif.res_ready;

    rep_d   = load ? rep_new : rep_q;
    valid_d = load || (valid_q && !xfer);
    drop_d  = drop || (drop_q && !load);
  end

  // Datapath and report registers.
  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      en_q       <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      width_q    <= '0;
      geom_q     <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      rep_q      <= '0;
    end else begin
      en_q       <= en_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      width_q    <= width_d;
      geom_q     <= geom_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      rep_q      <= rep_d;
    end
  end

  video_crc16_acc #(
    .PIX_W (PIX_W)
  ) u_crc (
    .clk   (video_clk_pix),
    .rst_n (video_rst_n),
    .clr   (fsm_frame_begin),
    .en    (fsm_pix_en),
    .data  ({vif.red, vif.green, vif.blue}),
    .crc   (crc_cur)
  );

  assign vif.res_valid    = valid_q;
  assign vif.res_width    = rep_q.width[COORDSPC-1:0];
  assign vif.res_height   = rep_q.height[COORDSPC-1:0];
  assign vif.res_crc      = rep_q.crc;
  assign vif.res_geom_err = rep_q.geom_err;
  assign vif.res_overrun  = rep_q.overrun;

endmodule

// File: doc/video_frame_monitor.md
Name: video_frame_monitor

Overview:
- Sink-side checker for the pixel stream produced by the video source: consumes the registered red/green/blue plus the frame_start, line_start and video_enable timing.
- Per frame, it measures active width and height, computes a CRC-16 over all active pixels and flags geometry errors.
- Each completed frame's result is offered on a valid/ready report port, used for HDMI-path self-test and for scoreboarding in simulation.

Parameters:
- COORDSPC, 16, width of the measured width/height counters (bits)
- COLSPC, 10, bits per colour channel
- H_RES, 1280, expected active pixels per line
- V_RES, 720, expected active lines per frame

Ports:
- video_clk_pix  in  1  pixel clock; all logic on its rising edge
- video_rst_n  in  1  reset, asynchronous assert, active-low
- video_enable  in  1  pixel on red/green/blue is active this cycle
- frame_start  in  1  one-cycle pulse at the start of a frame
- line_start  in  1  one-cycle pulse at the start of a line
- red / green / blue  in  COLSPC each  pixel colour
- res_valid  out  1  frame report available
- res_ready  in  1  consumer accepts the report
- res_width  out  COORDSPC  active pixel count of the first active line
- res_height  out  COORDSPC  active line count
- res_crc  out  16  CRC-16 of the frame's active pixels
- res_geom_err  out  1  a line width differed from H_RES, or height differed from V_RES
- res_overrun  out  1  at least one frame report was dropped since the last accepted report

Behaviour:
- Reset (video_rst_n low, async): all outputs 0; counters 0; CRC = 0xFFFF; FSM = IDLE. A reset mid-frame discards that frame; no report is produced for it.
- FSM has two states:
  - IDLE: ignore all input until frame_start, then go to MEASURE and clear the accumulators. The partial frame before the first frame_start is never reported.
  - MEASURE: accumulate, and stay in MEASURE.
- Pixel accumulation: each cycle with video_enable=1:
  - pix_cnt += 1, saturating at all-ones.
  - crc <= crc16_step(crc, {red,green,blue}). Polynomial 0x1021, 3*COLSPC data bits processed MSB first in one cycle, no final XOR.
- Line close: a line closes on the first cycle with video_enable=0 after a cycle with video_enable=1 (falling edge on the registered enable). On close:
  - line_cnt += 1, saturating.
  - If this is the first closed line of the frame, latch pix_cnt into width.
  - If pix_cnt != H_RES, set the sticky geom flag.
  - Clear pix_cnt.
- line_start resets pix_cnt only. A line_start in the middle of active video (enable high) therefore restarts the count without closing the line.
- Frame close, on frame_start while in MEASURE:
  - If a line is still open (enable was high the previous cycle), close it first using the same rules.
  - Form the report: height=line_cnt; geom_err = sticky geom flag OR (line_cnt != V_RES).
  - Clear all accumulators. A pixel with video_enable=1 in the same cycle as frame_start belongs to the new frame: the CRC restarts from 0xFFFF and that pixel is folded in.
- Report latency: res_* registered; res_valid rises the cycle after the frame_start edge.
- Handshake:
  - A transfer occurs on res_valid && res_ready.
  - While res_valid=1 and res_ready=0, all res_* hold stable.
  - res_valid drops after a transfer unless a new report loads in that same cycle.
  - If a transfer and a frame close happen in the same cycle, the new report loads, res_valid stays 1 and there is no overrun.
  - If a frame closes while res_valid=1 and res_ready=0, the new report is dropped and an internal drop flag is set. The next report loaded carries res_overrun=1, and the flag clears when that report transfers.
- A frame with zero active lines reports width=0, height=0, crc=0xFFFF, geom_err=1 (when V_RES != 0).

Decomposition:
- Shared package video_pkg holds:
  - CRC16_POLY = 16'h1021 and CRC16_INIT = 16'hFFFF
  - function crc16_step(crc, data), parameterised on 3*COLSPC
  - typedef frame_report_t {width, height, crc, geom_err, overrun}
- One sub-module, video_crc16_acc: registered accumulator with clr/en inputs, pixel data input and crc output. It uses the same reset as this block. The bench reuses crc16_step as its reference model.

Test Plan:
- Nominal (H_RES=4, V_RES=3): 2 frames of 3 lines × 4 enabled pixels, pixel values 0..11 → one report after the 2nd frame_start with width=4, height=3, geom_err=0, overrun=0, crc equal to the crc16_step model over pixels 0..11.
- Short line: line 2 has 3 pixels → width=4, height=3, geom_err=1. Extra 4th line → height=4, geom_err=1.
- Backpressure: res_ready=0 across 2 frame closes → first report held stable, second dropped. After res_ready=1, the 3rd frame's report shows overrun=1; the following report shows overrun=0.
- Simultaneous events: res_ready pulses in the same cycle as frame_start → res_valid stays 1 and overrun=0. A frame_start while video_enable=1 closes the open line and counts that pixel into the new frame's CRC.
- Reset mid-frame: drop video_rst_n after 5 pixels → outputs 0 immediately. The first frame_start after release produces no report; the next frame_start reports a clean frame.
- Saturation (COORDSPC=4): 20 enabled pixels in one line → width=15, geom_err=1.
